// File: rtl/spi_sync_slave.sv
// SPI mode-0 slave front end: oversamples SCLK/SS/MOSI in the clk domain and
// decodes 16-bit command/data frames into clk-synchronous register strobes.
module spi_sync_slave #(
    parameter int SYNCSTAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [7:0] rddata,
    output logic       miso,
    output logic       spioe,
    output logic [3:0] addr,
    output logic [7:0] wrtdata,
    output logic       we,
    output logic       rdt,
    output logic       abort
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNCSTAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q, settle_q;
    logic                  ss_s, sclk_s, mosi_s;
    logic                  ss_dly_q, sclk_dly_q;
    logic                  rise_q, fall_q, ss_rise_q, ss_fall_q;
    logic                  armed_q, w_q;
    state_t                state_q;
    logic [4:0]            cnt_q;
    logic [6:0]            rx_q;
    logic [7:0]            rx_d, tx_q;
    logic [3:0]            addr_q;
    logic [7:0]            wrtdata_q;
    logic                  we_q, rdt_q, abort_q;

    assign ss_s   = ss_sync_q[SYNCSTAGES-1];
    assign sclk_s = sclk_sync_q[SYNCSTAGES-1];
    assign mosi_s = mosi_sync_q[SYNCSTAGES-1];
    assign rx_d   = {rx_q, mosi_s};

    // Synchronizers, then edge pulses registered once more before the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            settle_q    <= '0;
            ss_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            ss_rise_q   <= 1'b0;
            ss_fall_q   <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNCSTAGES-2:0], ss};
            sclk_sync_q <= {sclk_sync_q[SYNCSTAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNCSTAGES-2:0], mosi};
            settle_q    <= {settle_q[SYNCSTAGES-2:0], 1'b1};
            ss_dly_q    <= ss_s;
            sclk_dly_q  <= sclk_s;
            rise_q      <= sclk_s & ~sclk_dly_q;
            fall_q      <= ~sclk_s & sclk_dly_q;
            ss_rise_q   <= ss_s & ~ss_dly_q;
            ss_fall_q   <= ~ss_s & ss_dly_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            w_q       <= 1'b0;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wrtdata_q <= '0;
            we_q      <= 1'b0;
            rdt_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            rdt_q   <= 1'b0;
            abort_q <= 1'b0;
            // Only arm once the flushed synchronizer shows ss high, so a frame
            // already in flight when reset releases is never picked up halfway.
            if (!armed_q && settle_q[SYNCSTAGES-1] && ss_s)
                armed_q <= 1'b1;
            // rddata gets one clk to settle on the new addr before capture.
            if (rdt_q)
                tx_q <= rddata;
            else if (state_q == DATA && fall_q && cnt_q > 5'd8)
                tx_q <= {tx_q[6:0], 1'b0};

            case (state_q)
                IDLE: begin
                    if (ss_fall_q && armed_q) begin
                        state_q <= CMD;
                        cnt_q   <= '0;
                        rx_q    <= '0;
                        tx_q    <= '0;
                    end
                end
                CMD: begin
                    if (rise_q) begin
                        rx_q  <= rx_d[6:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            addr_q  <= rx_d[3:0];
                            w_q     <= rx_q[6];
                            rdt_q   <= 1'b1;
                            state_q <= DATA;
                        end
                    end
                    if (ss_rise_q) begin
                        abort_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (rise_q) begin
                        rx_q  <= rx_d[6:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            state_q <= DONE;
                            if (w_q) begin
                                wrtdata_q <= rx_d;
                                we_q      <= 1'b1;
                            end
                        end
                    end
                    if (ss_rise_q) begin
                        if (!(rise_q && cnt_q == 5'd15))
                            abort_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    if (ss_rise_q)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso    = (state_q == DATA) & tx_q[7];
    assign spioe   = ~ss_s;
    assign addr    = addr_q;
    assign wrtdata = wrtdata_q;
    assign we      = we_q;
    assign rdt     = rdt_q;
    assign abort   = abort_q;

endmodule

// File: tb/tb_spi_sync_slave.sv
// Scoreboard bench for spi_sync_slave: frames are bit-banged on the SPI pins,
// expected strobes are queued at drive time and popped when the DUT pulses.
module tb_spi_sync_slave;
    localparam int SYNC = 2;
    localparam int HALF = 6;   // sclk half period in clk cycles

    logic       clk = 1'b0, reset = 1'b1, ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic [7:0] rddata;
    logic       miso, spioe, we, rdt, abort;
    logic [3:0] addr;
    logic [7:0] wrtdata;

    spi_sync_slave #(.SYNCSTAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .ss(ss), .sclk(sclk), .mosi(mosi),
        .rddata(rddata), .miso(miso), .spioe(spioe), .addr(addr),
        .wrtdata(wrtdata), .we(we), .rdt(rdt), .abort(abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd_model(input logic [3:0] a);
        return (a == 4'h0) ? 8'hA5 : {a, ~a};
    endfunction
    assign rddata = rd_model(addr);

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    ev_t we_q[$], rdt_q[$];
    ev_t mon_e;
    int  we_seen = 0, rdt_seen = 0, abort_seen = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                we_seen++;
                chk("we_pending", 32'(we_q.size() > 0), 1);
                if (we_q.size() > 0) begin
                    mon_e = we_q.pop_front();
                    chk("we_addr", 32'(addr), 32'(mon_e.a));
                    chk("we_data", 32'(wrtdata), 32'(mon_e.d));
                    chk("we_latency", cyc, mon_e.cyc);
                end
            end
            if (rdt) begin
                rdt_seen++;
                chk("rdt_pending", 32'(rdt_q.size() > 0), 1);
                if (rdt_q.size() > 0) begin
                    mon_e = rdt_q.pop_front();
                    chk("rdt_addr", 32'(addr), 32'(mon_e.a));
                    chk("rdt_latency", cyc, mon_e.cyc);
                end
            end
            if (abort) abort_seen++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full frame of nbits; strobes are queued before the rise that causes them.
    task automatic spi_xfer(input logic [23:0] frame, input int nbits);
        logic [7:0] cmd, rd;
        logic       m;
        ev_t        e;
        cmd = 8'(frame >> (nbits - 8));
        rd  = rd_model(cmd[3:0]);
        ss  = 1'b0;
        wait_clk(HALF);
        chk("spioe_active", 32'(spioe), 1);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[nbits-1-i];
            wait_clk(HALF);
            m = miso;
            if (i >= 8 && i < 16) chk($sformatf("miso_bit%0d", i), 32'(m), 32'(rd[15-i]));
            else if (i >= 16)     chk($sformatf("miso_done%0d", i), 32'(m), 0);
            sclk = 1'b1;
            if (i == 7) begin
                e.a = cmd[3:0]; e.d = 8'h00; e.cyc = cyc + SYNC + 2;
                rdt_q.push_back(e);
            end
            if (i == 15 && cmd[7]) begin
                e.a = cmd[3:0]; e.d = 8'(frame >> (nbits - 16)); e.cyc = cyc + SYNC + 2;
                we_q.push_back(e);
            end
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(2 * HALF);
        chk("spioe_idle", 32'(spioe), 0);
    endtask

    task automatic raw_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_miso"},    32'(miso), 0);
        chk({tag, "_spioe"},   32'(spioe), 0);
        chk({tag, "_addr"},    32'(addr), 0);
        chk({tag, "_wrtdata"}, 32'(wrtdata), 0);
        chk({tag, "_we"},      32'(we), 0);
        chk({tag, "_rdt"},     32'(rdt), 0);
        chk({tag, "_abort"},   32'(abort), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(4);
        chk_reset_outs("rst");
        reset = 1'b0;
        wait_clk(2 * HALF);

        // write 0x82 / 0x5A
        spi_xfer(24'h00825A, 16);
        chk("t1_we_cnt", we_seen, 1);
        chk("t1_rdt_cnt", rdt_seen, 1);
        chk("t1_abort_cnt", abort_seen, 0);
        chk("t1_addr", 32'(addr), 32'h2);
        chk("t1_wrtdata", 32'(wrtdata), 32'h5A);

        // read addr 0 (rddata 0xA5)
        spi_xfer(24'h000000, 16);
        chk("t2_we_cnt", we_seen, 1);
        chk("t2_rdt_cnt", rdt_seen, 2);

        // abort after 10 rises of write 0x8F
        spi_xfer(24'h00023E, 10);
        chk("t3_abort_cnt", abort_seen, 1);
        chk("t3_we_cnt", we_seen, 1);
        chk("t3_rdt_cnt", rdt_seen, 3);
        chk("t3_addr", 32'(addr), 32'hF);
        chk("t3_wrtdata", 32'(wrtdata), 32'h5A);

        // over-long 24-bit frame
        spi_xfer(24'h8433FF, 24);
        chk("t4_we_cnt", we_seen, 2);
        chk("t4_wrtdata", 32'(wrtdata), 32'h33);
        chk("t4_abort_cnt", abort_seen, 1);

        // back-to-back writes, ss high for 3 sclk periods between
        spi_xfer(24'h008111, 16);
        wait_clk(4 * HALF);
        spi_xfer(24'h008622, 16);
        chk("t5_we_cnt", we_seen, 4);
        chk("t5_addr", 32'(addr), 32'h6);
        chk("t5_wrtdata", 32'(wrtdata), 32'h22);

        // reset after 5 command bits with ss held low
        ss = 1'b0;
        wait_clk(HALF);
        raw_bits(16'h0010, 5);
        reset = 1'b1;
        wait_clk(3);
        chk_reset_outs("midrst");
        reset = 1'b0;
        raw_bits(16'h0377, 11);
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(2 * HALF);
        chk("t6_we_cnt", we_seen, 4);
        chk("t6_rdt_cnt", rdt_seen, 6);
        chk("t6_abort_cnt", abort_seen, 1);
        spi_xfer(24'h008377, 16);
        chk("t6_post_we_cnt", we_seen, 5);
        chk("t6_post_addr", 32'(addr), 32'h3);
        chk("t6_post_wrtdata", 32'(wrtdata), 32'h77);

        wait_clk(4);
        chk("we_queue_empty", 32'(we_q.size()), 0);
        chk("rdt_queue_empty", 32'(rdt_q.size()), 0);
        chk("abort_total", abort_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_sync_slave.md
Name: spi_sync_slave

Overview:
- SPI slave front end for the register decoder; sits directly upstream of it.
- Oversamples SCLK, SS and MOSI in the system clock domain.
- Decodes 16-bit frames into addr, wrtdata and single-cycle we/rdt strobes. All outputs are clk-synchronous, so no separate edge detector is needed downstream.
- Shifts the decoder's combinational rddata back out on MISO.

Parameters:
SYNCSTAGES, 2, flip-flop stages on each of sclk/ss/mosi before edge detection (min 2).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ss  input  1  SPI slave select, active low, asynchronous to clk
sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
mosi  input  1  SPI data in, MSB first
rddata  input  8  read data from decoder, valid combinationally for current addr
miso  output  1  SPI data out
spioe  output  1  MISO output enable; high while synchronized ss is low
addr  output  4  register address, held until next command byte completes
wrtdata  output  8  write data, held until next completed write
we  output  1  one-clk write strobe
rdt  output  1  one-clk read-transaction strobe
abort  output  1  one-clk pulse when a frame is cut short

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: miso=0, spioe=0, addr=0, wrtdata=0, we=0, rdt=0, abort=0. State is IDLE, bit counter is 0. Synchronizers load idle levels (ss=1, sclk=0, mosi=0).
- Timing requirement: clk at least 8x sclk; sclk high and low phases each at least SYNCSTAGES+2 clk periods.
- Synchronization: ss_s, sclk_s and mosi_s are the last sync stage. Edge detection compares sclk_s and ss_s with one extra registered copy. rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d.
- Frame format:
  - Byte 0 (command): bit7 = W (1 write, 0 read); bits6:4 ignored; bits3:0 = address.
  - Byte 1 (data): MOSI carries write data. MISO carries rddata on both reads and writes.
- State machine: IDLE, CMD, DATA, DONE.
  - IDLE: stays until ss_s falls (ss_s=0 while ss_d=1). Then enters CMD and clears the bit counter.
  - CMD: each rise shifts mosi_s into rx[0] and increments the count. On the 8th rise:
    - addr <= rx[2:0],mosi_s; W flag is latched.
    - rdt pulses high for exactly the next clk cycle, for both R and W, so the freeze logic always sees the access.
    - State goes to DATA.
  - DATA, transmit side:
    - In the cycle after rdt, tx <= rddata. This gives the decoder one clk to settle rddata after addr changes.
    - miso = tx[7] throughout DATA.
    - tx shifts left on every fall that occurs after the first DATA rise.
  - DATA, receive side: each rise shifts mosi_s into rx. On the 8th DATA rise (16th frame rise) the state goes to DONE. If W=1, wrtdata <= received byte and we pulses high for exactly the next clk cycle.
  - DONE: further rises are ignored. There is no second we or rdt, whatever the number of extra bits. Returns to IDLE on ss_s rise.
- Latency: we (and rdt) is high in the clk cycle following clk edge k+SYNCSTAGES+1, where edge k is the first clk edge that samples the 16th (8th) sclk rise at the pin. The bench checks this exact number.
- miso is 0 in IDLE, CMD and DONE. spioe = ~ss_s, independent of state.
- Abort: ss_s rises while in CMD, or in DATA before the 16th rise.
  - abort pulses for 1 clk and the state goes to IDLE.
  - No we is issued.
  - addr keeps its old value, or the new value if the command byte had completed.
  - An rdt already issued is not retracted.
- ss falling while in DONE (ss re-asserted without being seen high) is not possible given the timing requirement. If ss_s rises and falls on consecutive clk cycles, IDLE still takes the fall, so a new frame starts cleanly.
- Reset asserted mid-frame: reset values apply on the next clk edge, and the partial frame is discarded with no abort pulse. After reset deasserts with ss still low, the block waits for an ss_s fall and ignores the remainder of the current frame.
- Simultaneous events: an ss_s rise in the same cycle as the 16th rise completes the frame (we issued, no abort). sclk edges while ss_s=1 are ignored.

Test Plan:
- Write frame: command 0x82, data 0x5A. Expect addr=0x2, rdt one pulse, wrtdata=0x5A, exactly one we pulse at the specified latency, abort=0.
- Read frame: command 0x00, rddata model returns 0xA5 for addr 0. Expect rdt one pulse, no we, and MISO sampled on the 8 DATA rising edges = 1,0,1,0,0,1,0,1. spioe=1 only while ss low.
- Abort: ss raised after 10 sclk rises of command 0x8F. Expect addr=0xF, one rdt, one abort pulse, no we, wrtdata unchanged.
- Over-long frame: 24 sclk cycles, command 0x84, data 0x33 then 0xFF. Expect a single we with wrtdata=0x33, and miso=0 after bit 16.
- Back-to-back frames: two writes (0x81/0x11, 0x86/0x22) with ss high for 3 sclk periods between them. Expect two we pulses with correct addr/wrtdata pairs.
- Reset mid-frame: reset pulsed after 5 command bits with ss held low, then a full frame after ss toggles. Expect all outputs 0 after reset, no strobes from the broken frame, and the following frame decoded correctly.
